muldiv_unit: RTL and testbench

- Iterative 32-bit multiply/divide unit sitting beside the ALU in the execute stage.
- Consumes the same operand buses that feed the ALU and serves MULT/MULTU/DIV/DIVU, with HI/LO registers for MFHI/MFLO/MTHI/MTLO.
- Runs one operation at a time over multiple cycles and asserts busy so hazard logic stalls the pipeline.
- hi/lo outputs feed the execute-stage result mux alongside alu_out.

---
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the execute stage.
// Latency: start edge + 32 iteration cycles + 1 write cycle; busy stalls the pipeline.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    input  logic [1:0]       md_op,
    input  logic             start,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opd;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div0;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   q_res, r_res;

    always_comb begin
        a_neg     = ~md_op[0] & md_a[WIDTH-1];
        b_neg     = ~md_op[0] & md_b[WIDTH-1];
        a_mag     = a_neg ? (~md_a + 1'b1) : md_a;
        b_mag     = b_neg ? (~md_b + 1'b1) : md_b;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_trial = div_shift - {1'b0, opd};
        prod_res  = neg_q ? (~acc + 1'b1) : acc;
        // A zero divisor naturally leaves |a| in the remainder; re-signing it restores md_a.
        q_res     = div0 ? '1 : (neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0]);
        r_res     = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opd    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Divide: dividend shifts through acc, divisor in opd. Multiply: the reverse.
                        opd    <= md_op[1] ? b_mag : a_mag;
                        acc    <= {{WIDTH{1'b0}}, (md_op[1] ? a_mag : b_mag)};
                        is_div <= md_op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        div0   <= (md_b == '0);
                        cnt    <= CNT_W'(WIDTH);
                        busy   <= 1'b1;
                        state  <= BUSY;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                BUSY: begin
                    if (is_div) begin
                        if (!div_trial[WIDTH])
                            acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (is_div) begin
                        hi <= r_res;
                        lo <= q_res;
                    end else begin
                        hi <= prod_res[2*WIDTH-1:WIDTH];
                        lo <= prod_res[WIDTH-1:0];
                    end
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: result table plus timing/control corner sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] md_a, md_b, wdata;
    logic [1:0]  md_op;
    logic        start, flush, hi_we, lo_we;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .md_a(md_a), .md_b(md_b), .md_op(md_op),
        .start(start), .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_op = op; md_a = a; md_b = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        md_a = 32'hA5A5_A5A5; md_b = 32'h5A5A_5A5A; md_op = ~op;
    endtask

    // Wait (bounded) for busy to drop; sampled on falling edges.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    // Full operation with latency checks: k counts falling edges after the start edge.
    task automatic run_op(input int idx);
        int busy_cnt, done_k, done_cnt;
        string nm;
        nm = $sformatf("vec%0d", idx);
        launch(vecs[idx].op, vecs[idx].a, vecs[idx].b);
        busy_cnt = 0; done_k = -1; done_cnt = 0;
        for (int k = 0; k <= 34; k++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin done_k = k; done_cnt++; end
            if (k < 34) @(negedge clk);
        end
        check({nm, "_busy_cycles"}, busy_cnt, 33);
        check({nm, "_done_cycle"}, done_k, 32);
        check({nm, "_done_width"}, done_cnt, 1);
        check({nm, "_hi"}, hi, vecs[idx].exp_hi);
        check({nm, "_lo"}, lo, vecs[idx].exp_lo);
    endtask

    initial begin
        int seen_done;

        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd4,         32'h0000_0003, 32'hFFFF_FFFC};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFF, 32'd4,         32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vecs[2]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3]  = '{OP_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[4]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[5]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[6]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd4,         32'h0000_0003, 32'h3FFF_FFFF};
        vecs[7]  = '{OP_DIV,   32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
        vecs[8]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[9]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[10] = '{OP_MULTU, 32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        md_a = '0; md_b = '0; md_op = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_op(i);

        // MTHI then MTLO in IDLE
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
        @(negedge clk);
        lo_we = 1'b0;
        check("mthi", hi, 32'h1234);
        check("mtlo", lo, 32'h5678);

        // Both enables together
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_both_hi", hi, 32'hCAFE);
        check("mt_both_lo", lo, 32'hCAFE);

        // hi_we while busy is ignored
        launch(OP_MULTU, 32'd6, 32'd7);
        repeat (3) @(negedge clk);
        hi_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        hi_we = 1'b0;
        check("hi_we_busy_hold", hi, 32'hCAFE);
        wait_idle("hi_we_busy");
        check("hi_we_busy_hi", hi, 32'd0);
        check("hi_we_busy_lo", lo, 32'd42);

        // start with lo_we in the same IDLE cycle: write dropped
        @(negedge clk);
        md_op = OP_DIVU; md_a = 32'd100; md_b = 32'd7; start = 1'b1; lo_we = 1'b1; wdata = 32'hABCD;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        check("start_lo_we_busy", {31'd0, busy}, 32'd1);
        wait_idle("start_lo_we");
        check("start_lo_we_lo", lo, 32'd14);
        check("start_lo_we_hi", hi, 32'd2);

        // Flush at cycle 10: no done, hi/lo keep prior values
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        seen_done = 0;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) seen_done++;
            @(negedge clk);
        end
        check("flush_no_done", seen_done, 0);
        check("flush_hi", hi, 32'd2);
        check("flush_lo", lo, 32'd14);

        // flush overrides start in the same cycle
        md_op = OP_MULTU; md_a = 32'd2; md_b = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_over_start", {31'd0, busy}, 32'd0);

        // Second start while busy is ignored
        launch(OP_MULTU, 32'd9, 32'd11);
        repeat (5) @(negedge clk);
        md_op = OP_DIVU; md_a = 32'd1; md_b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("restart");
        check("restart_lo", lo, 32'd99);
        check("restart_hi", hi, 32'd0);
        repeat (2) @(negedge clk);
        check("restart_no_second", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-DIV
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
